// File: rtl/count_serializer.sv
// Serialises every change of the 4-bit count as start / 4 data bits LSB first / stop,
// with a one-deep pending buffer and sticky overrun. Optional parity bit: EVEN_PARITY_EN.
module count_serializer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic [3:0] z3_z0,
    input  logic       clr_ovr,
    output logic       out,
    output logic       busy,
    output logic       ovr
);

    localparam int TW = $clog2(BIT_CYCLES + 1);

`ifdef EVEN_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      bit_idx_q, bit_idx_d;
    logic [3:0]      shift_q, shift_d;
    logic [3:0]      prev_q, prev_d;
    logic [3:0]      pend_q, pend_d;
    logic            pend_v_q, pend_v_d;
    logic            out_q, out_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;
`ifdef EVEN_PARITY_EN
    logic            par_q, par_d;
`endif

    logic            evt;
    logic            last_bit;
    logic            load;
    logic [3:0]      load_val;
    logic            set_ovr;

    assign evt      = (z3_z0 != prev_q);
    assign last_bit = (timer_q == TW'(BIT_CYCLES - 1));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
        state_d   = state_q;
        timer_d   = last_bit ? '0 : timer_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        prev_d    = z3_z0;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        out_d     = out_q;
        busy_d    = busy_q;
        load      = 1'b0;
        load_val  = z3_z0;
        set_ovr   = 1'b0;
`ifdef EVEN_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            IDLE: begin
                timer_d = '0;
                load    = evt;
            end
            START: begin
                if (last_bit) begin
                    state_d   = DATA;
                    out_d     = shift_q[0];
                    bit_idx_d = 2'd0;
                end
            end
            DATA: begin
                if (last_bit) begin
                    if (bit_idx_q == 2'd3) begin
`ifdef EVEN_PARITY_EN
                        state_d = PAR;
                        out_d   = par_q;
`else
                        state_d = STOP;
                        out_d   = 1'b1;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        out_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 2'd1;
                    end
                end
            end
`ifdef EVEN_PARITY_EN
            PAR: begin
                if (last_bit) begin
                    state_d = STOP;
                    out_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (last_bit) begin
                    // A fresh change beats the pending value; the pending one is then lost.
                    if (evt) begin
                        load     = 1'b1;
                        set_ovr  = pend_v_q;
                        pend_v_d = 1'b0;
                    end else if (pend_v_q) begin
                        load     = 1'b1;
                        load_val = pend_q;
                        pend_v_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        out_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                out_d   = 1'b1;
            end
        endcase

        if (evt && (state_q != IDLE) && !((state_q == STOP) && last_bit)) begin
            pend_d   = z3_z0;
            pend_v_d = 1'b1;
            set_ovr  = pend_v_q;
        end

        if (load) begin
            shift_d = load_val;
            state_d = START;
            out_d   = 1'b0;
            busy_d  = 1'b1;
`ifdef EVEN_PARITY_EN
            par_d   = ^load_val;
`endif
        end

        ovr_d = (ovr_q & ~clr_ovr) | set_ovr;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= 2'd0;
            shift_q   <= 4'd0;
            prev_q    <= 4'd0;
            pend_q    <= 4'd0;
            pend_v_q  <= 1'b0;
            out_q     <= 1'b1;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef EVEN_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
`ifdef EVEN_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign ovr  = ovr_q;

endmodule
